// File: rtl/namuru_time_base.sv
// -----------------------------------------------------------------------------
// namuru_time_base
//
// Time-base scheduler for the Namuru GPS correlator. Divides the ADC sample
// strobe into the TIC epoch (pre_tic_enable followed one cycle later by
// tic_enable), the accumulation period (accum_enable) and a re-timed sample
// strobe for the correlators (accum_sample_enable). The live divider counters
// are exposed for software readback.
//
// Ports:
//   sys_clk              system clock, rising edge
//   rstn                 asynchronous active-low reset
//   samp_en              one-cycle ADC sample strobe
//   resync               request to restart both dividers on the next samp_en
//   tic_divide           TIC period minus one, in samples
//   accum_divide         accumulation period minus one, in samples
//   accum_sample_enable  samp_en delayed one cycle, only while running
//   pre_tic_enable       pulse one cycle ahead of tic_enable
//   tic_enable           TIC epoch pulse
//   accum_enable         accumulation-period pulse
//   tic_count            current TIC down-counter value
//   accum_count          current accumulation down-counter value
//   running              high once the dividers have been loaded
// -----------------------------------------------------------------------------
module namuru_time_base #(
  parameter int TIC_W = 24,
  parameter int ACC_W = 24
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             samp_en,
  input  logic             resync,
  input  logic [TIC_W-1:0] tic_divide,
  input  logic [ACC_W-1:0] accum_divide,
  output logic             accum_sample_enable,
  output logic             pre_tic_enable,
  output logic             tic_enable,
  output logic             accum_enable,
  output logic [TIC_W-1:0] tic_count,
  output logic [ACC_W-1:0] accum_count,
  output logic             running
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [TIC_W-1:0] r_tic_cnt;
  logic [ACC_W-1:0] r_acc_cnt;
  logic             r_resync_pend;
  logic             r_samp_en;
  logic             r_pre_tic;
  logic             r_tic_en;
  logic             r_acc_en;
  logic             r_running;

  // A resync request taken now or left pending from an earlier cycle.
  logic w_resync_req;
  assign w_resync_req = resync | r_resync_pend;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_tic_cnt     <= '0;
      r_acc_cnt     <= '0;
      r_resync_pend <= 1'b0;
      r_samp_en     <= 1'b0;
      r_pre_tic     <= 1'b0;
      r_tic_en      <= 1'b0;
      r_acc_en      <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every right-hand side read the
      // pre-edge value, so r_tic_en takes last cycle's r_pre_tic no matter
      // what the branches below do to r_pre_tic this cycle.
      r_tic_en  <= r_pre_tic;
      r_pre_tic <= 1'b0;
      r_acc_en  <= 1'b0;
      r_samp_en <= samp_en && (r_state == ST_RUN);

      case (r_state)
        ST_IDLE: begin
          if (samp_en) begin
            // First strobe only loads; a resync seen here is absorbed.
            r_tic_cnt     <= tic_divide;
            r_acc_cnt     <= accum_divide;
            r_resync_pend <= 1'b0;
            r_running     <= 1'b1;
            r_state       <= ST_RUN;
          end else if (resync) begin
            r_resync_pend <= 1'b1;
          end
        end

        ST_RUN: begin
          if (samp_en) begin
            if (w_resync_req) begin
              // Restart both dividers silently.
              r_tic_cnt     <= tic_divide;
              r_acc_cnt     <= accum_divide;
              r_resync_pend <= 1'b0;
            end else begin
              if (r_tic_cnt == '0) begin
                r_tic_cnt <= tic_divide;
                r_pre_tic <= 1'b1;
              end else begin
                r_tic_cnt <= r_tic_cnt - TIC_W'(1);
              end

              if (r_acc_cnt == '0) begin
                r_acc_cnt <= accum_divide;
                r_acc_en  <= 1'b1;
              end else begin
                r_acc_cnt <= r_acc_cnt - ACC_W'(1);
              end
            end
          end else if (resync) begin
            r_resync_pend <= 1'b1;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign accum_sample_enable = r_samp_en;
  assign pre_tic_enable      = r_pre_tic;
  assign tic_enable          = r_tic_en;
  assign accum_enable        = r_acc_en;
  assign tic_count           = r_tic_cnt;
  assign accum_count         = r_acc_cnt;
  assign running             = r_running;

endmodule

// File: doc/namuru_time_base.md
Name: namuru_time_base

Overview:
- Time-base scheduler for the Namuru GPS correlator; sits between the control interface and the tracking channels.
- Divides the ADC sample strobe into three periodic events:
  - the TIC epoch, as a pre_tic_enable / tic_enable pair, which channels use to latch carrier/code/epoch measurements;
  - the accumulation interrupt period (accum_enable);
  - a re-timed sample strobe (accum_sample_enable) for the correlators.
- Exposes live counter values for software readback.

Parameters:
TIC_W, 24, width of TIC divider and tic_count
ACC_W, 24, width of accumulation divider and accum_count

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
samp_en  in  1  one-cycle ADC sample strobe (may be high on consecutive cycles)
resync  in  1  one-cycle request to restart both dividers on the next samp_en
tic_divide  in  TIC_W  TIC period minus one, in samples
accum_divide  in  ACC_W  accumulation period minus one, in samples
accum_sample_enable  out  1  samp_en delayed one cycle, gated by RUN state
pre_tic_enable  out  1  one-cycle pulse, one cycle before tic_enable
tic_enable  out  1  one-cycle TIC pulse
accum_enable  out  1  one-cycle accumulation-period pulse
tic_count  out  TIC_W  current TIC down-counter value
accum_count  out  ACC_W  current accumulation down-counter value
running  out  1  high in RUN state

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; tic_cnt and acc_cnt = 0; resync_pend = 0; all outputs 0.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE:
  - first samp_en loads tic_cnt <= tic_divide and acc_cnt <= accum_divide;
  - goes to RUN; no pulses generated.
- State RUN, on each samp_en:
  - accum_sample_enable is high the next cycle.
  - tic_cnt == 0: reload tic_divide; pre_tic_enable high the next cycle; tic_enable high the cycle after that. Otherwise tic_cnt decrements.
  - acc_cnt == 0: reload accum_divide; accum_enable high the next cycle. Otherwise acc_cnt decrements.
- Periods: TIC period = tic_divide+1 samp_en strobes; accumulation period = accum_divide+1 strobes.
- Divide = 0: pulse on every samp_en. With back-to-back samp_en, pre_tic_enable and tic_enable are each high continuously, with tic_enable lagging by one cycle.
- Divider writes take effect only at the next reload. Counters never load mid-period.
- Latency: samp_en at cycle N with tic_cnt == 0 gives pre_tic_enable at N+1 and tic_enable at N+2. This spacing is exact and independent of further samp_en activity.
- The TIC and accumulation dividers are independent. pre_tic_enable, tic_enable and accum_enable may coincide in any combination.
- tic_count / accum_count reflect the counter registers directly: they read the reloaded value in the cycle after a reload.
- resync:
  - sets resync_pend;
  - on the next samp_en in RUN, both counters load their divide values with no pulses generated, and resync_pend clears;
  - resync concurrent with samp_en applies on that same samp_en;
  - resync in IDLE is absorbed by the normal IDLE load.
- A pre_tic_enable already issued still produces its tic_enable, even if resync or a reload intervenes.
- Reset mid-operation: everything clears immediately, including any pending tic_enable; the IDLE load sequence restarts after release.

Test Plan:
- Reset release, tic_divide=3, accum_divide=7, samp_en every cycle:
  - first strobe loads only;
  - pre_tic_enable every 4th cycle, tic_enable one cycle later;
  - accum_enable every 8th cycle;
  - tic_count cycles 3,2,1,0.
- samp_en every 5th cycle, tic_divide=1:
  - pre_tic_enable 1 cycle and tic_enable 2 cycles after every 2nd strobe;
  - accum_sample_enable 1 cycle after each strobe.
- tic_divide=0, accum_divide=0, samp_en continuous:
  - pre_tic_enable, tic_enable and accum_enable all held high, with tic_enable lagging by one cycle.
- tic_divide changed 3->9 mid-period:
  - current period still 4 strobes, then 10-strobe periods;
  - accumulation period unaffected.
- resync pulse while tic_cnt=2 and acc_cnt=5:
  - next samp_en reloads both counters with no pulses;
  - next pre_tic_enable after tic_divide+1 further strobes.
- rstn asserted the cycle after pre_tic_enable:
  - tic_enable never asserts; all outputs 0 immediately, running=0;
  - after release, first samp_en reloads only.
